// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared FSM state type and default sizing for mem_access_master
// Contents:
//   DEFAULT_MEMORY_WIDTH   : default data word width in bits
//   DEFAULT_MEMORY_DEPTH   : default number of memory locations
//   DEFAULT_TIMEOUT_CYCLES : default ready_i wait limit (timeout build only)
//   state_e                : burst sequencer states
package mem_access_pkg;

  localparam int DEFAULT_MEMORY_WIDTH   = 8;
  localparam int DEFAULT_MEMORY_DEPTH   = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    GET_WDATA,
    REQ,
    DONE
  } state_e;

endpackage

// File: rtl/mem_access_master.sv
// rtl/mem_access_master.sv - burst read/write master driving a valid/ready memory port
// Build option: MEM_ACCESS_MASTER_TIMEOUT_EN enables the ready_i wait timeout and err_o.
// Ports:
//   clk_i, rst_i                    : clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o         : command handshake (cmd_wr_rd_i, cmd_addr_i, cmd_len_i)
//   wr_valid_i/wr_ready_o/wr_data_i : write-data input stream
//   rd_valid_o/rd_data_o/rd_last_o  : read-data output stream, no backpressure
//   valid_o/wr_rd_o/addr_o/wdata_o  : memory request, accepted when ready_i = 1
//   rdata_i                         : memory read data, sampled in the transfer cycle
//   done_o                          : one-cycle burst-complete pulse
//   err_o                           : sticky timeout flag (0 when the timeout is not built)
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int MEMORY_WIDTH   = DEFAULT_MEMORY_WIDTH,
  parameter int MEMORY_DEPTH   = DEFAULT_MEMORY_DEPTH,
  parameter int ADDRESS_WIDTH  = $clog2(MEMORY_DEPTH),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_wr_rd_i,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDRESS_WIDTH:0]   cmd_len_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [MEMORY_WIDTH-1:0]  wr_data_i,
  output logic                     rd_valid_o,
  output logic [MEMORY_WIDTH-1:0]  rd_data_o,
  output logic                     rd_last_o,
  output logic                     valid_o,
  output logic                     wr_rd_o,
  output logic [ADDRESS_WIDTH-1:0] addr_o,
  output logic [MEMORY_WIDTH-1:0]  wdata_o,
  input  logic                     ready_i,
  input  logic [MEMORY_WIDTH-1:0]  rdata_i,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int LEN_W = ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
  localparam logic [LEN_W-1:0]         LEN_ONE   = LEN_W'(1);

  state_e                   state_q, state_d;
  logic                     wr_rd_q, wr_rd_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [MEMORY_WIDTH-1:0]  wdata_q, wdata_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [MEMORY_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                     rd_last_q, rd_last_d;
  logic                     done_q, done_d;
  logic                     timeout_hit;

  always_comb begin
    state_d    = state_q;
    wr_rd_d    = wr_rd_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_last_d  = 1'b0;
    // done_o is registered so it appears the cycle after DONE, i.e. two
    // cycles after acceptance of a zero-length command.
    done_d     = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          wr_rd_d = cmd_wr_rd_i;
          addr_d  = cmd_addr_i;
          len_d   = cmd_len_i;
          if (cmd_len_i == '0) begin
            state_d = DONE;
          end else if (cmd_wr_rd_i) begin
            state_d = GET_WDATA;
          end else begin
            state_d = REQ;
          end
        end
      end
      GET_WDATA: begin
        if (wr_valid_i) begin
          wdata_d = wr_data_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ready_i) begin
          // Wrap explicitly so non-power-of-two depths stay in range.
          addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
          len_d  = len_q - LEN_ONE;
          if (!wr_rd_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rdata_i;
            rd_last_d  = (len_q == LEN_ONE);
          end
          if (len_q == LEN_ONE) begin
            state_d = DONE;
          end else if (wr_rd_q) begin
            state_d = GET_WDATA;
          end
        end else if (timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_rd_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_rd_q    <= wr_rd_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
    end
  end

`ifdef MEM_ACCESS_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  // The counter holds the number of stalled REQ cycles already seen, so the
  // limit fires on the TIMEOUT_CYCLES-th consecutive cycle without ready_i.
  assign timeout_hit = (state_q == REQ) && !ready_i && (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d = '0;
    err_d    = err_q | timeout_hit;
    if ((state_q == REQ) && !ready_i) begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
  assign err_o          = 1'b0;
`endif

  // cmd_ready_o is gated by rst_i so every output reads 0 while reset is held.
  assign cmd_ready_o = (state_q == IDLE) && !rst_i;
  assign wr_ready_o  = (state_q == GET_WDATA);
  assign valid_o     = (state_q == REQ);
  assign wr_rd_o     = wr_rd_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_last_o   = rd_last_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_mem_access_master.sv
// tb/tb_mem_access_master.sv - self-checking bench for mem_access_master
module tb_mem_access_master;

  localparam int MW = 8;
  localparam int MD = 16;
  localparam int AW = 4;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_wr_rd_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [MW-1:0] wr_data_i = '0;
  logic          rd_valid_o;
  logic [MW-1:0] rd_data_o;
  logic          rd_last_o;
  logic          valid_o;
  logic          wr_rd_o;
  logic [AW-1:0] addr_o;
  logic [MW-1:0] wdata_o;
  logic          ready_i = 1'b1;
  logic [MW-1:0] rdata_i;
  logic          done_o;
  logic          err_o;

  always #5 clk = ~clk;

  mem_access_master #(
    .MEMORY_WIDTH(MW), .MEMORY_DEPTH(MD), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_rd_i(cmd_wr_rd_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .valid_o(valid_o), .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .ready_i(ready_i), .rdata_i(rdata_i), .done_o(done_o), .err_o(err_o)
  );

  // Memory seen by the DUT.
  logic [MW-1:0] mem_arr [MD];
  assign rdata_i = mem_arr[addr_o];
  always @(posedge clk) begin
    if (!rst_i && valid_o && ready_i && wr_rd_o) mem_arr[addr_o] <= wdata_o;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a burst is a list of (dir, addr, data) transfers with
  // addresses (start + i) mod depth; reads return whatever the model memory held.
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
  } xfer_t;
  typedef struct packed {
    logic [MW-1:0] data;
    logic          last;
  } rd_t;

  logic [MW-1:0] model_mem [MD];
  xfer_t exp_xfer[$];
  rd_t   exp_rd[$];

  task automatic model_push(input logic wr, input int addr, input int len, input logic [MW-1:0] base);
    int a;
    xfer_t x;
    rd_t r;
    a = addr;
    for (int i = 0; i < len; i++) begin
      x.wr   = wr;
      x.addr = AW'(a);
      x.data = wr ? (base + MW'(i)) : model_mem[a];
      if (wr) begin
        model_mem[a] = x.data;
      end else begin
        r.data = model_mem[a];
        r.last = (i == len - 1);
        exp_rd.push_back(r);
      end
      exp_xfer.push_back(x);
      a = (a + 1) % MD;
    end
  endtask

  // Observation logs, appended only by the compare process.
  int            xfer_cnt = 0;
  int            rd_cnt = 0;
  int            valid_cycles = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            acc_cyc = 0;
  logic [AW-1:0] addr_log[$];
  int            xfer_cyc_log[$];
  logic [MW-1:0] rd_data_log[$];
  logic          rd_last_log[$];

  logic          have_prev = 1'b0;
  logic          prev_valid, prev_ready;
  logic [AW-1:0] prev_addr;
  logic [MW-1:0] prev_wdata;
  xfer_t         ex;
  rd_t           er;

  always @(negedge clk) begin
    if (rst_i) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_valid && !prev_ready && !err_o) begin
        check("req_hold_valid", 64'(valid_o), 64'(1));
        check("req_hold_addr", 64'(addr_o), 64'(prev_addr));
        check("req_hold_wdata", 64'(wdata_o), 64'(prev_wdata));
      end
      if (valid_o) valid_cycles++;
      if (valid_o && ready_i) begin
        xfer_cnt++;
        addr_log.push_back(addr_o);
        xfer_cyc_log.push_back(cyc);
        check("xfer_expected", 64'(exp_xfer.size() != 0), 64'(1));
        if (exp_xfer.size() != 0) begin
          ex = exp_xfer.pop_front();
          check("xfer_dir", 64'(wr_rd_o), 64'(ex.wr));
          check("xfer_addr", 64'(addr_o), 64'(ex.addr));
          if (ex.wr) check("xfer_wdata", 64'(wdata_o), 64'(ex.data));
        end
      end
      if (rd_valid_o) begin
        rd_cnt++;
        rd_data_log.push_back(rd_data_o);
        rd_last_log.push_back(rd_last_o);
        check("rd_expected", 64'(exp_rd.size() != 0), 64'(1));
        if (exp_rd.size() != 0) begin
          er = exp_rd.pop_front();
          check("rd_data", 64'(rd_data_o), 64'(er.data));
          check("rd_last", 64'(rd_last_o), 64'(er.last));
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
`ifndef MEM_ACCESS_MASTER_TIMEOUT_EN
      check("err_tied_low", 64'(err_o), 64'(0));
`endif
      prev_valid = valid_o;
      prev_ready = ready_i;
      prev_addr  = addr_o;
      prev_wdata = wdata_o;
      have_prev  = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input int addr, input int len);
    int n;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b1;
    cmd_wr_rd_i = wr;
    cmd_addr_i  = AW'(addr);
    cmd_len_i   = LW'(len);
    n = 0;
    step();
    while (!cmd_ready_o && n < 50) begin
      step();
      n++;
    end
    check("cmd_accepted", 64'(cmd_ready_o), 64'(1));
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  // Must be entered just after a rising edge (as send_cmd leaves it).
  task automatic send_wdata(input int len, input logic [MW-1:0] base);
    int n;
    for (int i = 0; i < len; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = base + MW'(i);
      n = 0;
      step();
      while (!wr_ready_o && n < 100) begin
        step();
        n++;
      end
      check("wdata_accepted", 64'(wr_ready_o), 64'(1));
      @(posedge clk);
      #1;
    end
    wr_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      step();
      n++;
    end
    check("done_seen", 64'(done_cnt), 64'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int b, vb, rb, n, db;
    logic [3:0] lastv;

    // Reset state: everything low while reset is held.
    @(posedge clk);
    #1;
    check("reset_outputs", 64'({cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o, rd_last_o, valid_o,
                                wr_rd_o, addr_o, wdata_o, done_o, err_o}), 64'(0));
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    check("cmd_ready_after_reset", 64'(cmd_ready_o), 64'(1));

    // Write burst addr 0, len 16, data 0x00..0x0F.
    b = xfer_cnt;
    n = xfer_cyc_log.size();
    model_push(1'b1, 0, 16, 8'h00);
    send_cmd(1'b1, 0, 16);
    send_wdata(16, 8'h00);
    wait_done(1);
    repeat (3) step();
    check("wr16_done_single", 64'(done_cnt), 64'(1));
    check("wr16_xfers", 64'(xfer_cnt - b), 64'(16));
    check("wr16_rate", 64'(xfer_cyc_log[n + 15] - xfer_cyc_log[n]), 64'(30));
    for (int i = 0; i < 16; i++) check("wr16_mem", 64'(mem_arr[i]), 64'(i));
    check("wr16_drained", 64'(exp_xfer.size()), 64'(0));

    // Read burst addr 14, len 4: wraps 14,15,0,1.
    n  = addr_log.size();
    rb = rd_data_log.size();
    model_push(1'b0, 14, 4, 8'h00);
    send_cmd(1'b0, 14, 4);
    wait_done(2);
    step();
    check("rd4_addr0", 64'(addr_log[n]), 64'(14));
    check("rd4_addr1", 64'(addr_log[n + 1]), 64'(15));
    check("rd4_addr2", 64'(addr_log[n + 2]), 64'(0));
    check("rd4_addr3", 64'(addr_log[n + 3]), 64'(1));
    check("rd4_rate", 64'(xfer_cyc_log[n + 3] - xfer_cyc_log[n]), 64'(3));
    check("rd4_pulses", 64'(rd_data_log.size() - rb), 64'(4));
    check("rd4_data0", 64'(rd_data_log[rb]), 64'(8'h0E));
    check("rd4_data3", 64'(rd_data_log[rb + 3]), 64'(8'h01));
    lastv = {rd_last_log[rb + 3], rd_last_log[rb + 2], rd_last_log[rb + 1], rd_last_log[rb]};
    check("rd4_last_pattern", 64'(lastv), 64'(4'b1000));
    check("rd4_drained", 64'(exp_rd.size()), 64'(0));

    // ready_i low for 3 REQ cycles: request held 4 cycles, one transfer.
    ready_i = 1'b0;
    b  = xfer_cnt;
    model_push(1'b1, 5, 1, 8'hA5);
    send_cmd(1'b1, 5, 1);
    send_wdata(1, 8'hA5);
    vb = valid_cycles;
    n = 0;
    while (!valid_o && n < 20) begin
      step();
      n++;
    end
    check("stall_valid_seen", 64'(valid_o), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    ready_i = 1'b1;
    wait_done(3);
    check("stall_valid_cycles", 64'(valid_cycles - vb), 64'(4));
    check("stall_xfers", 64'(xfer_cnt - b), 64'(1));
    check("stall_mem", 64'(mem_arr[5]), 64'(8'hA5));

    // Zero-length command: no access, done_o two cycles after acceptance.
    b  = xfer_cnt;
    vb = valid_cycles;
    send_cmd(1'b1, 9, 0);
    wait_done(4);
    check("len0_done_latency", 64'(done_cyc - acc_cyc), 64'(2));
    check("len0_no_valid", 64'(valid_cycles - vb), 64'(0));

    // len 18 from addr 14: wraps, later writes overwrite earlier ones.
    model_push(1'b1, 14, 18, 8'h40);
    send_cmd(1'b1, 14, 18);
    send_wdata(18, 8'h40);
    wait_done(5);
    step();
    check("wrap_mem14", 64'(mem_arr[14]), 64'(8'h50));
    check("wrap_mem0", 64'(mem_arr[0]), 64'(8'h42));
    check("wrap_mem5", 64'(mem_arr[5]), 64'(8'h47));
    check("wrap_mem13", 64'(mem_arr[13]), 64'(8'h4F));
    for (int i = 0; i < MD; i++) check("wrap_mem_model", 64'(mem_arr[i]), 64'(model_mem[i]));

    // Reset after 5 of 10 reads.
    rb = rd_cnt;
    model_push(1'b0, 0, 10, 8'h00);
    send_cmd(1'b0, 0, 10);
    n = 0;
    while (rd_cnt - rb < 5 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_mid_reads_seen", 64'(rd_cnt - rb), 64'(5));
    rst_i = 1'b1;
    #1;
    check("rst_mid_outputs", 64'({cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o, rd_last_o, valid_o,
                                  wr_rd_o, addr_o, wdata_o, done_o, err_o}), 64'(0));
    exp_xfer.delete();
    exp_rd.delete();
    db = done_cnt;
    rb = rd_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    check("rst_mid_cmd_ready", 64'(cmd_ready_o), 64'(1));
    repeat (5) step();
    check("rst_mid_no_done", 64'(done_cnt), 64'(db));
    check("rst_mid_no_rd", 64'(rd_cnt), 64'(rb));
    model_push(1'b0, 3, 2, 8'h00);
    send_cmd(1'b0, 3, 2);
    wait_done(db + 1);
    check("rst_new_cmd_reads", 64'(rd_cnt - rb), 64'(2));
    check("rst_new_cmd_drained", 64'(exp_rd.size()), 64'(0));

`ifdef MEM_ACCESS_MASTER_TIMEOUT_EN
    // ready_i stuck low: err_o after 16 REQ cycles, then done_o.
    ready_i = 1'b0;
    b  = xfer_cnt;
    vb = valid_cycles;
    db = done_cnt;
    send_cmd(1'b0, 2, 3);
    n = 0;
    while (!err_o && n < 60) begin
      step();
      n++;
    end
    check("timeout_err", 64'(err_o), 64'(1));
    check("timeout_valid_cycles", 64'(valid_cycles - vb), 64'(16));
    check("timeout_valid_dropped", 64'(valid_o), 64'(0));
    wait_done(db + 1);
    check("timeout_no_xfer", 64'(xfer_cnt - b), 64'(0));
    repeat (3) step();
    check("timeout_err_sticky", 64'(err_o), 64'(1));
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    check("timeout_err_cleared", 64'(err_o), 64'(0));
`endif

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
